// File: rtl/rr_arbiter_16_if.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter_16_if
// Brief    : Request/grant and output handshake bundle for rr_arbiter_16.
// Revision : 1.0 - initial release
// ============================================================================
interface rr_arbiter_16_if;
  logic [15:0]  req;
  logic [511:0] req_data;
  logic [15:0]  gnt;
  logic [31:0]  out_data;
  logic [3:0]   out_src;
  logic         out_valid;
  logic         out_ready;
  logic [15:0]  xfer_count;

  modport master (
    output req, req_data, out_ready,
    input  gnt, out_data, out_src, out_valid, xfer_count
  );

  modport slave (
    input  req, req_data, out_ready,
    output gnt, out_data, out_src, out_valid, xfer_count
  );
endinterface
`default_nettype wire

// File: rtl/rr_arbiter_16.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter_16
// Brief    : 16-way round-robin arbiter feeding a one-deep registered output.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter_16 (
  input  logic           clock,
  input  logic           reset,
  rr_arbiter_16_if.slave bus
);

  logic [3:0]  r_ptr;
  logic [31:0] r_out_data;
  logic [3:0]  r_out_src;
  logic        r_out_valid;
  logic [15:0] r_xfer_count;

  logic [31:0] w_words [16];
  logic        w_found;
  logic [3:0]  w_win;
  logic [3:0]  w_idx;
  logic        w_slot_free;
  logic        w_grant;

  for (genvar g = 0; g < 16; g++) begin : g_words
    assign w_words[g] = bus.req_data[32*g +: 32];
  end

  // Scan from ptr upward, wrapping through the 4-bit index; first hit wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = 4'd0;
    w_idx   = 4'd0;
    for (int k = 0; k < 16; k++) begin
      w_idx = r_ptr + 4'(k);
      if (!w_found && bus.req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_slot_free = !r_out_valid || bus.out_ready;
  assign w_grant     = w_found && w_slot_free && !reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ptr        <= 4'd0;
      r_out_data   <= 32'h0;
      r_out_src    <= 4'h0;
      r_out_valid  <= 1'b0;
      r_xfer_count <= 16'h0;
    end else begin
      if (r_out_valid && bus.out_ready) begin
        r_xfer_count <= r_xfer_count + 16'd1;
      end
      if (w_grant) begin
        r_out_data  <= w_words[w_win];
        r_out_src   <= w_win;
        r_out_valid <= 1'b1;
        r_ptr       <= w_win + 4'd1;
      end else if (w_slot_free) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.gnt        = w_grant ? (16'd1 << w_win) : 16'd0;
  assign bus.out_data   = r_out_data;
  assign bus.out_src    = r_out_src;
  assign bus.out_valid  = r_out_valid;
  assign bus.xfer_count = r_xfer_count;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_16.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arbiter_16
// Brief    : Directed self-checking bench for rr_arbiter_16.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter_16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   fails  = 0;

  rr_arbiter_16_if bus ();

  rr_arbiter_16 dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] req;
    logic        rdy;
    logic [15:0] gnt;
    logic        valid;
    logic [3:0]  src;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    bus.req       = 16'h0;
    bus.out_ready = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int hs;
    logic [31:0] held_data;

    // ptr sequence: 0,1,1,1,2,3,3,0,1,1,1,9 -> expected winners below
    vecs[0]  = '{16'h0001, 1'b1, 16'h0001, 1'b1, 4'd0};
    vecs[1]  = '{16'h0001, 1'b1, 16'h0001, 1'b1, 4'd0};
    vecs[2]  = '{16'h0000, 1'b1, 16'h0000, 1'b0, 4'd0};
    vecs[3]  = '{16'h0006, 1'b1, 16'h0002, 1'b1, 4'd1};
    vecs[4]  = '{16'h0006, 1'b1, 16'h0004, 1'b1, 4'd2};
    vecs[5]  = '{16'h0006, 1'b0, 16'h0000, 1'b1, 4'd2};
    vecs[6]  = '{16'h8001, 1'b1, 16'h8000, 1'b1, 4'd15};
    vecs[7]  = '{16'h8001, 1'b1, 16'h0001, 1'b1, 4'd0};
    vecs[8]  = '{16'h0000, 1'b0, 16'h0000, 1'b1, 4'd0};
    vecs[9]  = '{16'h0000, 1'b1, 16'h0000, 1'b0, 4'd0};
    vecs[10] = '{16'h0100, 1'b0, 16'h0100, 1'b1, 4'd8};
    vecs[11] = '{16'h0300, 1'b1, 16'h0200, 1'b1, 4'd9};

    bus.req       = 16'hFFFF;
    bus.out_ready = 1'b1;
    bus.req_data  = '0;
    #1;
    check("gnt_in_reset", 32'(bus.gnt), 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    bus.req = 16'h0;
    check("rst_valid", 32'(bus.out_valid), 32'h0);
    check("rst_data", bus.out_data, 32'h0);
    check("rst_src", 32'(bus.out_src), 32'h0);
    check("rst_count", 32'(bus.xfer_count), 32'h0);

    // Table-driven pass
    for (int i = 0; i < 16; i++) bus.req_data[32*i +: 32] = 32'hA000_0000 | 32'(i);
    for (int v = 0; v < 12; v++) begin
      bus.req       = vecs[v].req;
      bus.out_ready = vecs[v].rdy;
      #1;
      check($sformatf("vec%0d_gnt", v), 32'(bus.gnt), 32'(vecs[v].gnt));
      @(posedge clock);
      #1;
      check($sformatf("vec%0d_valid", v), 32'(bus.out_valid), 32'(vecs[v].valid));
      check($sformatf("vec%0d_src", v), 32'(bus.out_src), 32'(vecs[v].src));
      check($sformatf("vec%0d_data", v), bus.out_data, 32'hA000_0000 | 32'(vecs[v].src));
    end

    // Single request, then priority moves to index 1
    do_reset();
    bus.req_data[31:0] = 32'hDEADBEEF;
    bus.req = 16'h0001;
    bus.out_ready = 1'b1;
    #1;
    check("single_gnt", 32'(bus.gnt), 32'h0001);
    tick();
    check("single_valid", 32'(bus.out_valid), 32'h1);
    check("single_data", bus.out_data, 32'hDEADBEEF);
    check("single_src", 32'(bus.out_src), 32'h0);
    bus.req = 16'h0003;
    #1;
    check("single_next_gnt", 32'(bus.gnt), 32'h0002);

    // Full contention walks 0..15,0
    do_reset();
    for (int i = 0; i < 16; i++) bus.req_data[32*i +: 32] = 32'(i);
    bus.req = 16'hFFFF;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 17; c++) begin
      #1;
      check($sformatf("walk%0d_gnt", c), 32'(bus.gnt), 32'h1 << (c % 16));
      tick();
      check($sformatf("walk%0d_src", c), 32'(bus.out_src), 32'(c % 16));
      check($sformatf("walk%0d_data", c), bus.out_data, 32'(c % 16));
      check($sformatf("walk%0d_count", c), 32'(bus.xfer_count), 32'(c));
    end

    // Wrap: grant 14, then 15, 3, 15
    do_reset();
    bus.out_ready = 1'b1;
    bus.req = 16'h4000;
    #1;
    check("wrap_g14", 32'(bus.gnt), 32'h4000);
    tick();
    bus.req = 16'h8008;
    #1;
    check("wrap_g15a", 32'(bus.gnt), 32'h8000);
    tick();
    check("wrap_g3", 32'(bus.gnt), 32'h0008);
    tick();
    check("wrap_g15b", 32'(bus.gnt), 32'h8000);

    // Backpressure for 5 cycles with req on bit 4
    do_reset();
    bus.req_data[32*4 +: 32] = 32'h4444_4444;
    bus.req = 16'h0010;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    held_data = 32'h4444_4444;
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("bp%0d_gnt", c), 32'(bus.gnt), 32'h0);
      tick();
      check($sformatf("bp%0d_data", c), bus.out_data, held_data);
      check($sformatf("bp%0d_src", c), 32'(bus.out_src), 32'd4);
      check($sformatf("bp%0d_valid", c), 32'(bus.out_valid), 32'h1);
      check($sformatf("bp%0d_count", c), 32'(bus.xfer_count), 32'h0);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_gnt", 32'(bus.gnt), 32'h0010);
    tick();
    check("bp_release_count", 32'(bus.xfer_count), 32'h1);
    check("bp_release_valid", 32'(bus.out_valid), 32'h1);

    // Reset with a held word and ptr=9
    do_reset();
    bus.out_ready = 1'b1;
    bus.req = 16'h0080;
    tick();
    tick();
    bus.req = 16'h0100;
    tick();
    check("mid_count_pre", 32'(bus.xfer_count), 32'h2);
    bus.out_ready = 1'b0;
    reset = 1'b1;
    bus.req = 16'hFFFF;
    #1;
    check("mid_gnt_in_reset", 32'(bus.gnt), 32'h0);
    tick();
    reset = 1'b0;
    check("mid_valid", 32'(bus.out_valid), 32'h0);
    check("mid_count", 32'(bus.xfer_count), 32'h0);
    check("mid_src", 32'(bus.out_src), 32'h0);
    check("mid_data", bus.out_data, 32'h0);
    bus.out_ready = 1'b1;
    #1;
    check("mid_first_gnt", 32'(bus.gnt), 32'h0001);

    // 65536 handshakes bring the counter back to zero
    do_reset();
    bus.req = 16'hFFFF;
    bus.out_ready = 1'b1;
    hs = 0;
    for (int c = 0; c < 70000; c++) begin
      if (bus.out_valid && bus.out_ready) hs++;
      tick();
      if (hs == 65535) check("cnt_ffff", 32'(bus.xfer_count), 32'h0000FFFF);
      if (hs == 65536) break;
    end
    check("cnt_done", 32'(hs), 32'd65536);
    check("cnt_wrap", 32'(bus.xfer_count), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rr_arbiter_16.md
RR_ARBITER_16 -- requirements
Module: rr_arbiter_16

Interface
REQ-001 SHALL have port clock, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port req, input, 16 bits: req[i] high = requester i holds a valid 32-bit word.
REQ-004 SHALL have port req_data, input, 512 bits: requester i word on bits [32i+31:32i].
REQ-005 SHALL have port gnt, output, 16 bits: one-hot acceptance; gnt[i] high = requester i's word captured at this clock edge.
REQ-006 SHALL have port out_data, output, 32 bits: registered word selected from the winning requester.
REQ-007 SHALL have port out_src, output, 4 bits: index of the requester that supplied out_data.
REQ-008 SHALL have port out_valid, output, 1 bit: out_data/out_src hold an undelivered word.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer accepts the word when out_valid and out_ready are both high.
REQ-010 SHALL have port xfer_count, output, 16 bits: number of completed output handshakes.

Function
REQ-011 SHALL keep a 4-bit round-robin pointer ptr; highest priority is ptr, then ptr+1, ..., wrapping modulo 16.
REQ-012 SHALL define slot_free = !out_valid | out_ready.
REQ-013 SHALL select as winner the first i with req[i]=1 in the priority order, only when slot_free=1 and reset=0.
REQ-014 SHALL drive gnt combinationally: exactly one bit high for the winner, else all zero; never more than one bit high.
REQ-015 SHALL, on a clock edge with a winner w: load out_data <= req_data word w via a 16:1 select indexed by w; load out_src <= w; set out_valid <= 1; set ptr <= (w+1) mod 16, so 15 wraps to 0.
REQ-016 SHALL, on an edge with slot_free=1 and no req bit high: clear out_valid; leave ptr, out_data and out_src unchanged.
REQ-017 SHALL, while out_valid=1 and out_ready=0: hold out_data, out_src, out_valid and ptr stable and keep gnt=0.
REQ-018 SHALL allow a drain and a new accept in the same cycle, sustaining one word per cycle while out_ready=1.
REQ-019 SHALL present an accepted word on out_data exactly one cycle after its gnt pulse (latency 1).
REQ-020 SHALL increment xfer_count on each edge where out_valid & out_ready; it wraps 16'hFFFF -> 16'h0000.
REQ-021 SHALL grant any continuously asserted req[i] within at most 16 accepts (no starvation).
REQ-022 SHALL not require requesters to drop req after gnt; a held req competes again from the new ptr.

Reset
REQ-023 SHALL, on an edge with reset=1: set ptr=0, out_valid=0, out_data=32'h0, out_src=4'h0, xfer_count=16'h0.
REQ-024 SHALL hold gnt=16'h0 in any cycle with reset=1, regardless of req.
REQ-025 SHALL discard any held undelivered word on reset without counting it; the first post-reset grant uses priority order from index 0.

Verification
REQ-026 Single request: after reset, req=16'h0001, word0=32'hDEADBEEF, out_ready=1 -> gnt=16'h0001 in cycle N; cycle N+1 out_valid=1, out_data=32'hDEADBEEF, out_src=0; next priority starts at index 1.
REQ-027 Full contention: req=16'hFFFF, out_ready=1 held, word i = i -> gnt walks bits 0,1,...,15,0 on successive cycles; out_src/out_data show 0..15,0 one cycle later; xfer_count increments every cycle.
REQ-028 Wrap: after a grant to 14, req=16'h8008 -> grant 15, then 3, then 15.
REQ-029 Backpressure: out_valid=1, out_ready=0 for 5 cycles with req=16'h0010 -> out_data/out_src stable, gnt=0, xfer_count unchanged; with out_ready=1 -> handshake and gnt=16'h0010 in the same cycle.
REQ-030 Reset mid-operation: out_valid=1, out_ready=0, ptr=9; reset high 1 cycle with req=16'hFFFF -> gnt=0 during reset; afterwards out_valid=0, xfer_count=0; the first grant goes to bit 0.
REQ-031 Counter wrap: 65536 consecutive handshakes from reset -> xfer_count returns to 16'h0000.
